// File: rtl/gsr_pur_pkg.sv
// Shared constants and helpers for the global set/reset and power-up reset net generator.
package gsr_pur_pkg;

    localparam string GSR_ENABLED  = "ENABLED";
    localparam string GSR_DISABLED = "DISABLED";

    // Bits needed to hold a counter that runs from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gsr_pur_sync.sv
// Flop chain that brings the asynchronous GSR_N request into the CLKI domain.
module gsr_pur_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Reset to 0 so the request reads as asserted until the chain has filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            chain <= '0;
        else
            chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gsr_pur_assign_unit.sv
// Drives the active-low PURNET and GSRNET global nets that primitive models fold into
// their internal set/reset.
module gsr_pur_assign_unit
    import gsr_pur_pkg::*;
#(
    parameter string GSR            = "ENABLED",
    parameter int    PUR_CYCLES     = 16,
    parameter int    GSR_MIN_CYCLES = 4,
    parameter int    SYNC_STAGES    = 2
) (
    output logic GSRNET,
    output logic PURNET,
    input  logic CLKI,
    input  logic RST,
    input  logic GSR_N
);

    localparam int PUR_W = cnt_width(PUR_CYCLES);
    localparam int STR_W = cnt_width(GSR_MIN_CYCLES);
    localparam logic [PUR_W-1:0] PUR_MAX  = PUR_W'(PUR_CYCLES);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(GSR_MIN_CYCLES);
    localparam bit GSR_EN = (GSR != GSR_DISABLED);

    logic [PUR_W-1:0] pur_cnt;
    logic [PUR_W-1:0] pur_cnt_nxt;
    logic [STR_W-1:0] cnt;
    logic             sync_q;
    logic             gsr_nxt;

    gsr_pur_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (CLKI),
        .rst (RST),
        .d   (GSR_N),
        .q   (sync_q)
    );

    // PURNET is decoded from the post-edge count so it rises on the PUR_CYCLES-th edge.
    assign pur_cnt_nxt = (pur_cnt == PUR_MAX) ? pur_cnt : pur_cnt + PUR_W'(1);

    assign gsr_nxt = GSR_EN ? (PURNET & sync_q & (cnt == '0)) : PURNET;

    always_ff @(posedge CLKI or posedge RST) begin
        if (RST) begin
            pur_cnt <= '0;
            PURNET  <= 1'b0;
        end else begin
            pur_cnt <= pur_cnt_nxt;
            PURNET  <= (pur_cnt_nxt == PUR_MAX);
        end
    end

    // A live request keeps reloading the stretch, so back-to-back requests merge.
    always_ff @(posedge CLKI or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (!sync_q)
            cnt <= STR_LOAD;
        else if (cnt != '0)
            cnt <= cnt - STR_W'(1);
    end

    always_ff @(posedge CLKI or posedge RST) begin
        if (RST)
            GSRNET <= 1'b0;
        else
            GSRNET <= gsr_nxt;
    end

endmodule

// File: tb/tb_gsr_pur_assign_unit.sv
// Directed bench: default, GSR-disabled and single-cycle power-up variants side by side.
module tb_gsr_pur_assign_unit;

    typedef struct {
        logic gsr_n;
        logic exp_gsr;
        logic exp_pur;
    } vec_t;

    localparam int NVEC = 65;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gsr_n_a = 1'b1;
    logic gsr_n_b = 1'b1;
    logic gsr_n_c = 1'b1;
    logic gsr_a, pur_a, gsr_b, pur_b, gsr_c, pur_c;

    int checks = 0;
    int errors = 0;

    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    gsr_pur_assign_unit u_a (
        .GSRNET (gsr_a), .PURNET (pur_a), .CLKI (clk), .RST (rst), .GSR_N (gsr_n_a)
    );

    gsr_pur_assign_unit #(
        .GSR ("DISABLED")
    ) u_b (
        .GSRNET (gsr_b), .PURNET (pur_b), .CLKI (clk), .RST (rst), .GSR_N (gsr_n_b)
    );

    gsr_pur_assign_unit #(
        .PUR_CYCLES (1), .GSR_MIN_CYCLES (0)
    ) u_c (
        .GSRNET (gsr_c), .PURNET (pur_c), .CLKI (clk), .RST (rst), .GSR_N (gsr_n_c)
    );

    task automatic chk(input string name, input int n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %b expected %b", name, n, act, exp);
        end
    endtask

    // Expectations for all three units n edges after reset release with no A/C request.
    task automatic chk_powerup(input int n);
        chk("a_pur", n, pur_a, n >= 16);
        chk("a_gsr", n, gsr_a, n >= 17);
        chk("b_pur", n, pur_b, n >= 16);
        chk("b_gsr", n, gsr_b, n >= 17);
        chk("c_pur", n, pur_c, 1'b1);
        chk("c_gsr", n, gsr_c, n >= 3);
    endtask

    initial begin
        // Edge n of the run is tbl[n-1]; request edges and GSRNET low windows hand-derived.
        for (int n = 1; n <= NVEC; n++)
            tbl[n-1] = '{gsr_n: 1'b1, exp_gsr: (n >= 17), exp_pur: (n >= 16)};
        // 3-edge request: sync_q low after edges 32..34, GSRNET low after 33..39.
        for (int n = 31; n <= 33; n++) tbl[n-1].gsr_n = 1'b0;
        for (int n = 33; n <= 39; n++) tbl[n-1].exp_gsr = 1'b0;
        // Request at 45..47 retriggered by a 1-edge request at 50: low after 47..56.
        for (int n = 45; n <= 47; n++) tbl[n-1].gsr_n = 1'b0;
        tbl[49].gsr_n = 1'b0;
        for (int n = 47; n <= 56; n++) tbl[n-1].exp_gsr = 1'b0;

        #1;
        chk("rst0_a_pur", 0, pur_a, 1'b0);
        chk("rst0_a_gsr", 0, gsr_a, 1'b0);
        chk("rst0_c_pur", 0, pur_c, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_pur", 0, pur_a, 1'b0);
        chk("rst_a_gsr", 0, gsr_a, 1'b0);
        chk("rst_b_gsr", 0, gsr_b, 1'b0);
        chk("rst_c_pur", 0, pur_c, 1'b0);
        chk("rst_c_gsr", 0, gsr_c, 1'b0);
        rst = 1'b0;

        for (int n = 1; n <= NVEC; n++) begin
            gsr_n_a = tbl[n-1].gsr_n;
            gsr_n_b = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("a_gsr", n, gsr_a, tbl[n-1].exp_gsr);
            chk("a_pur", n, pur_a, tbl[n-1].exp_pur);
            chk("a_gsr_le_pur", n, gsr_a & ~pur_a, 1'b0);
            chk("b_pur", n, pur_b, n >= 16);
            chk("b_gsr", n, gsr_b, n >= 17);
            chk("c_pur", n, pur_c, 1'b1);
            chk("c_gsr", n, gsr_c, n >= 3);
        end

        // Reset between edges must clear the nets without waiting for CLKI.
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_a_pur", 0, pur_a, 1'b0);
        chk("mid_rst_a_gsr", 0, gsr_a, 1'b0);
        chk("mid_rst_b_gsr", 0, gsr_b, 1'b0);
        chk("mid_rst_c_pur", 0, pur_c, 1'b0);
        #1;
        rst = 1'b0;

        for (int n = 1; n <= 20; n++) begin
            gsr_n_a = 1'b1;
            gsr_n_b = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk_powerup(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gsr_pur_assign_unit.md
Name: gsr_pur_assign_unit

Overview:
Generates the two active-low global reset nets that primitive models AND together into their internal set/reset: PURNET (power-up reset) and GSRNET (global set/reset). PURNET is held low for a fixed number of clocks after reset release. GSRNET follows PURNET and a synchronized, pulse-stretched user request. This block replaces the hierarchical GSR_INST/PUR_INST net references in mixed-HDL builds.

Parameters:
GSR, "ENABLED", "ENABLED": the GSR_N request drives GSRNET; "DISABLED": GSRNET equals PURNET and GSR_N is ignored.
PUR_CYCLES, 16, number of CLKI rising edges PURNET stays low after RST deasserts; legal range is 1 or more.
GSR_MIN_CYCLES, 4, minimum extra low time (in clocks) appended to any GSR request.
SYNC_STAGES, 2, flop depth of the GSR_N synchronizer; legal range is 2 or more.

Ports:
CLKI  input  1  single clock; all flops use its rising edge.
RST  input  1  asynchronous, active-high reset.
GSR_N  input  1  asynchronous, active-low user global set/reset request.
GSRNET  output  1  active-low global set/reset net; 1 means not asserted.
PURNET  output  1  active-low power-up reset net; 1 means not asserted.
Positional declaration order: GSRNET, PURNET, CLKI, RST, GSR_N. This keeps existing two-output positional instantiations valid.

Behaviour:
- RST=1 asynchronously forces the following, and holds them while RST is high:
  - PURNET=0, GSRNET=0
  - PUR counter = 0, stretch counter = 0
  - every synchronizer flop = 0 (request asserted)
- PUR counter:
  - Width is clog2(PUR_CYCLES+1).
  - Increments on each rising edge while below PUR_CYCLES, then saturates.
  - PURNET is registered and equals (counter == PUR_CYCLES). It therefore rises exactly on the PUR_CYCLES-th rising edge after RST falls.
- Synchronizer: GSR_N passes through a SYNC_STAGES-deep flop chain; call the last stage sync_q.
- Stretch counter (cnt):
  - If sync_q == 0, load cnt = GSR_MIN_CYCLES.
  - Else if cnt != 0, decrement cnt.
  - Else hold.
- GSRNET register, using pre-edge values:
  - GSR="ENABLED": next GSRNET = PURNET & sync_q & (cnt == 0).
  - GSR="DISABLED": next GSRNET = PURNET, giving a 1-cycle lag behind PURNET.
- Timing consequences:
  - A GSR_N low pulse that yields L low cycles of sync_q drives GSRNET low for exactly L + GSR_MIN_CYCLES cycles.
  - GSRNET begins falling 1 clock after sync_q falls.
- A new request during a stretch reloads cnt (retrigger); GSRNET stays low continuously.
- GSRNET can never be 1 while PURNET is 0.
- RST asserted mid-operation clears everything and restarts the PUR count from 0.
- No X propagation:
  - Every flop has an asynchronous reset value.
  - Outputs are known from the first RST assertion onward.

Decomposition:
- Shared package gsr_pur_pkg holds:
  - string constants GSR_ENABLED / GSR_DISABLED
  - a function computing counter width from PUR_CYCLES and GSR_MIN_CYCLES
- One natural sub-module: gsr_pur_sync, a parameterized SYNC_STAGES flop chain with async active-high reset to 0.

Test Plan:
- Power-up, defaults, GSR_N=1: pulse RST, release before edge 1 → PURNET=0 through edge 15, PURNET=1 after edge 16, GSRNET=1 after edge 17.
- GSR request: steady state, GSR_N low for 3 clocks → GSRNET low for exactly 3+4=7 consecutive cycles, starting 1 clock after sync_q falls (SYNC_STAGES=2). PURNET stays 1 throughout.
- Retrigger: second 1-cycle GSR_N pulse while GSRNET is still low → GSRNET stays low and rises 4 cycles after the second pulse's sync_q low cycle ends.
- Async reset mid-run: RST=1 between clock edges at cycle 40 → PURNET and GSRNET drop to 0 immediately with no edge; after release, PURNET returns to 1 after 16 edges.
- GSR="DISABLED": toggle GSR_N arbitrarily → GSRNET always equals PURNET delayed 1 cycle and never drops after PURNET=1.
- PUR_CYCLES=1 → PURNET=1 after the first edge post-release; GSRNET stays 0 until sync_q=1, then rises (edge 3 with SYNC_STAGES=2).
